// File: rtl/sel_mux_buffered.sv
// sel_mux_buffered: NUM_IN:1 word selector with a 2-entry output buffer.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_bus     packed input words; word i = in_bus[i*WIDTH +: WIDTH]
//   sel        word index, sampled at the accept edge
//   in_valid   request present
//   in_ready   buffer can accept a request (registered)
//   out_data   selected word at buffer head (registered)
//   out_sel    sel value that produced out_data (registered)
//   out_err    head entry had sel >= NUM_IN (registered)
//   out_valid  buffer head valid (registered)
//   out_ready  consumer accepts the head
//   xfer_cnt   wrapping count of completed output transfers
module sel_mux_buffered #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 32,
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] mux_word;
    logic             mux_err;

    // Second (tail) entry; the head entry lives directly in the output registers.
    logic [WIDTH-1:0] tail_data;
    logic [SEL_W-1:0] tail_sel;
    logic             tail_err;

    logic push;
    logic pop;
    logic head_load;
    logic head_from_tail;
    logic tail_load;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Word select; an out-of-range index matches no word and yields zero.
    always_comb begin
        mux_word = '0;
        mux_err  = (32'(sel) >= 32'(NUM_IN));
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                mux_word = in_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy next-state and entry movement controls.
    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_from_tail = 1'b0;
        tail_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt = ONE;
                    head_load = 1'b1;
                end
            end
            ONE: begin
                case ({push, pop})
                    2'b10: begin
                        state_nxt = FULL;
                        tail_load = 1'b1;
                    end
                    2'b01: begin
                        state_nxt = EMPTY;
                    end
                    2'b11: begin
                        // Head leaves and the new entry replaces it in the same edge.
                        state_nxt = ONE;
                        head_load = 1'b1;
                    end
                    default: begin
                        state_nxt = ONE;
                    end
                endcase
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State, handshake flags and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            xfer_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            // Flags track the next state so they stay free of combinational input paths.
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
            if (pop) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
        end
    end

    // Head and tail entry storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            tail_data <= '0;
            tail_sel  <= '0;
            tail_err  <= 1'b0;
        end else begin
            if (head_load) begin
                out_data <= mux_word;
                out_sel  <= sel;
                out_err  <= mux_err;
            end else if (head_from_tail) begin
                out_data <= tail_data;
                out_sel  <= tail_sel;
                out_err  <= tail_err;
            end
            if (tail_load) begin
                tail_data <= mux_word;
                tail_sel  <= sel;
                tail_err  <= mux_err;
            end
        end
    end

endmodule
